// File: rtl/ps2_scancode_fifo.sv
// PS/2 Set-2 scancode decoder and event FIFO.
// Folds E0/F0/E1 prefix sequences into single 16-bit key events, queues them
// for the CPU keyboard port and routes keyboard control replies to sys_byte.
module ps2_scancode_fifo #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               ps2_data,
    input  logic                     ps2_data_clk,
    input  logic                     rd_pop,
    input  logic                     flush,
    input  logic                     ovf_clr,
    output logic [15:0]              rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               sys_byte,
    output logic                     sys_strobe
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_PAUSE
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      skip, skip_nx;
    logic [TW-1:0]   tmo_cnt, tmo_nx;
    logic            strobe_q;
    logic            accept;
    logic            is_ctrl;
    logic            dec_push;
    logic [15:0]     dec_data;
    logic            dec_sys;
    logic            push_pend;
    logic [15:0]     push_data;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, do_push, do_pop, ovf_set;

    assign accept = ps2_data_clk & ~strobe_q;

    // Recognise keyboard control replies (ACK, BAT, echo, resend, errors)
    always_comb begin
        is_ctrl = 1'b0;
        case (ps2_data)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_ctrl = 1'b1;
            default: is_ctrl = 1'b0;
        endcase
    end

    // Prefix decoder: next state, pause skip count, stall timer and the event to emit
    always_comb begin
        state_nx = state;
        skip_nx  = skip;
        tmo_nx   = tmo_cnt;
        dec_push = 1'b0;
        dec_data = 16'h0000;
        dec_sys  = 1'b0;
        if (accept) begin
            tmo_nx = '0;
            case (state)
                ST_IDLE: begin
                    if (ps2_data == 8'hE0) begin
                        state_nx = ST_E0;
                    end else if (ps2_data == 8'hF0) begin
                        state_nx = ST_F0;
                    end else if (ps2_data == 8'hE1) begin
                        state_nx = ST_PAUSE;
                        skip_nx  = 3'd7;
                    end else if (is_ctrl) begin
                        dec_sys = 1'b1;
                    end else begin
                        dec_push = 1'b1;
                        dec_data = {8'h00, ps2_data};
                    end
                end
                ST_E0: begin
                    if (ps2_data == 8'hF0) begin
                        state_nx = ST_E0F0;
                    end else if (ps2_data == 8'hE0) begin
                        state_nx = ST_E0;
                    end else if (ps2_data == 8'hE1) begin
                        state_nx = ST_PAUSE;
                        skip_nx  = 3'd7;
                    end else begin
                        dec_push = 1'b1;
                        dec_data = {8'h40, ps2_data};
                        state_nx = ST_IDLE;
                    end
                end
                ST_F0: begin
                    if (ps2_data == 8'hE0) begin
                        state_nx = ST_E0;
                    end else begin
                        dec_push = 1'b1;
                        dec_data = {8'h80, ps2_data};
                        state_nx = ST_IDLE;
                    end
                end
                ST_E0F0: begin
                    state_nx = ST_IDLE;
                    if (ps2_data != 8'hF0 && ps2_data != 8'hE0) begin
                        dec_push = 1'b1;
                        dec_data = {8'hC0, ps2_data};
                    end
                end
                ST_PAUSE: begin
                    if (skip == 3'd1) begin
                        dec_push = 1'b1;
                        dec_data = 16'h60E1;
                        skip_nx  = 3'd0;
                        state_nx = ST_IDLE;
                    end else begin
                        skip_nx = skip - 3'd1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end else if (state == ST_IDLE) begin
            tmo_nx = '0;
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state_nx = ST_IDLE;
            skip_nx  = 3'd0;
            tmo_nx   = '0;
        end else begin
            tmo_nx = tmo_cnt + 1'b1;
        end
    end

    // Decoder state, strobe edge detector, and the one-cycle-delayed push/status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            skip       <= 3'd0;
            tmo_cnt    <= '0;
            strobe_q   <= 1'b0;
            push_pend  <= 1'b0;
            push_data  <= 16'h0000;
            sys_byte   <= 8'h00;
            sys_strobe <= 1'b0;
        end else if (flush) begin
            state      <= ST_IDLE;
            skip       <= 3'd0;
            tmo_cnt    <= '0;
            strobe_q   <= 1'b0;
            push_pend  <= 1'b0;
            push_data  <= 16'h0000;
            sys_strobe <= 1'b0;
        end else begin
            state      <= state_nx;
            skip       <= skip_nx;
            tmo_cnt    <= tmo_nx;
            strobe_q   <= ps2_data_clk;
            push_pend  <= dec_push;
            push_data  <= dec_data;
            sys_strobe <= dec_sys;
            if (dec_sys) begin
                sys_byte <= ps2_data;
            end
        end
    end

    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = rd_pop & (count != '0);
    assign do_push = push_pend & (~full | do_pop);
    assign ovf_set = push_pend & full & ~do_pop;

    // FIFO storage, pointers and occupancy; a pop on a full FIFO frees room for a same-cycle push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Sticky overflow flag; a clear request wins over a same-cycle drop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end else if (!flush && ovf_set) begin
            overflow <= 1'b1;
        end
    end

    assign rd_data  = mem[rd_ptr];
    assign rd_valid = (count != '0);

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Testbench for ps2_scancode_fifo: prefix decoding vectors, FIFO corner cases,
// timeout, async reset, and randomized traffic against an event-queue model.
module tb_ps2_scancode_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic        clk;
    logic        reset_n;
    logic [7:0]  ps2_data;
    logic        ps2_data_clk;
    logic        rd_pop;
    logic        flush;
    logic        ovf_clr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  sys_byte;
    logic        sys_strobe;

    ps2_scancode_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_data     (ps2_data),
        .ps2_data_clk (ps2_data_clk),
        .rd_pop       (rd_pop),
        .flush        (flush),
        .ovf_clr      (ovf_clr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .overflow     (overflow),
        .sys_byte     (sys_byte),
        .sys_strobe   (sys_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int sys_pulses = 0;

    // Count sys_strobe pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (sys_strobe === 1'b1) sys_pulses <= sys_pulses + 1;
    end

    // Vector: up to 8 bytes, left-justified, first byte in bits [63:56]
    typedef struct {
        int          n;
        logic [63:0] bytes;
        int          n_ev;
        logic [15:0] ev;
        int          n_sys;
        logic [7:0]  sysb;
    } vec_t;

    vec_t vecs[12];

    // Reference model: queued events, pending prefix flags, pause bytes still to swallow
    logic [15:0] exp_q[$];
    logic        m_ext, m_rel;
    int          m_skip;
    logic        m_ovf;
    logic [7:0]  m_sysb;
    int          m_sys_cnt;

    task automatic modelReset();
        exp_q.delete();
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endtask

    task automatic modelEvent(input logic [15:0] ev);
        if (exp_q.size() == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(ev);
    endtask

    task automatic modelByte(input logic [7:0] b);
        logic ctrl;
        ctrl = (b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF);
        if (m_skip > 0) begin
            m_skip--;
            if (m_skip == 0) modelEvent(16'h60E1);
        end else if (!m_ext && !m_rel) begin
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_rel = 1'b1;
            else if (b == 8'hE1) m_skip = 7;
            else if (ctrl) begin
                m_sysb = b;
                m_sys_cnt++;
            end else modelEvent({8'h00, b});
        end else if (m_ext && !m_rel) begin
            if (b == 8'hF0) m_rel = 1'b1;
            else if (b == 8'hE1) begin
                m_ext  = 1'b0;
                m_skip = 7;
            end else if (b != 8'hE0) begin
                modelEvent({8'h40, b});
                m_ext = 1'b0;
            end
        end else if (!m_ext && m_rel) begin
            m_rel = 1'b0;
            if (b == 8'hE0) m_ext = 1'b1;
            else modelEvent({8'h80, b});
        end else begin
            m_ext = 1'b0;
            m_rel = 1'b0;
            if (b != 8'hF0 && b != 8'hE0) modelEvent({8'hC0, b});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic sendByte(input logic [7:0] b, input int hold);
        ps2_data     = b;
        ps2_data_clk = 1'b1;
        repeat (hold) tick();
        ps2_data_clk = 1'b0;
        repeat (4) tick();
        modelByte(b);
    endtask

    task automatic popOnce();
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        tick();
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic flushDut();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        modelReset();
    endtask

    task automatic applyStimulus(input int idx);
        logic [63:0] bs;
        bs = vecs[idx].bytes;
        for (int k = 0; k < vecs[idx].n; k++) begin
            sendByte(bs[63 - 8 * k -: 8], (idx == 0) ? 3 : 1 + (k % 3));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".rd_data"}, rd_data, 16'h0000);
        checkOutput({tag, ".rd_valid"}, 16'(rd_valid), 16'h0000);
        checkOutput({tag, ".count"}, 16'(count), 16'h0000);
        checkOutput({tag, ".overflow"}, 16'(overflow), 16'h0000);
        checkOutput({tag, ".sys_byte"}, 16'(sys_byte), 16'h0000);
        checkOutput({tag, ".sys_strobe"}, 16'(sys_strobe), 16'h0000);
    endtask

    logic [7:0]  ctrl_list [6];
    logic [15:0] drain_exp [8];

    initial begin
        int base;
        int act;
        logic [7:0] b;

        vecs[0]  = '{1, 64'h1C00_0000_0000_0000, 1, 16'h001C, 0, 8'h00};
        vecs[1]  = '{3, 64'hE0F0_7500_0000_0000, 1, 16'hC075, 0, 8'h00};
        vecs[2]  = '{2, 64'hF01C_0000_0000_0000, 1, 16'h801C, 0, 8'h00};
        vecs[3]  = '{8, 64'hE114_77E1_F014_F077, 1, 16'h60E1, 0, 8'h00};
        vecs[4]  = '{2, 64'hFAAA_0000_0000_0000, 0, 16'h0000, 2, 8'hAA};
        vecs[5]  = '{2, 64'hF0FA_0000_0000_0000, 1, 16'h80FA, 0, 8'h00};
        vecs[6]  = '{2, 64'hE075_0000_0000_0000, 1, 16'h4075, 0, 8'h00};
        vecs[7]  = '{3, 64'hF0E0_7500_0000_0000, 1, 16'h4075, 0, 8'h00};
        vecs[8]  = '{3, 64'hE0F0_E000_0000_0000, 0, 16'h0000, 0, 8'h00};
        vecs[9]  = '{3, 64'hE0E0_1C00_0000_0000, 1, 16'h401C, 0, 8'h00};
        vecs[10] = '{1, 64'hEE00_0000_0000_0000, 0, 16'h0000, 1, 8'hEE};
        vecs[11] = '{1, 64'h0000_0000_0000_0000, 0, 16'h0000, 1, 8'h00};

        ctrl_list = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

        reset_n      = 1'b0;
        ps2_data     = 8'h00;
        ps2_data_clk = 1'b0;
        rd_pop       = 1'b0;
        flush        = 1'b0;
        ovf_clr      = 1'b0;
        m_ovf        = 1'b0;
        m_sysb       = 8'h00;
        m_sys_cnt    = 0;
        modelReset();
        repeat (3) tick();
        checkAllZero("reset");
        reset_n = 1'b1;
        tick();

        // Table-driven decoding vectors
        for (int i = 0; i < 12; i++) begin
            flushDut();
            base = sys_pulses;
            applyStimulus(i);
            checkOutput($sformatf("vec%0d.count", i), 16'(count), 16'(vecs[i].n_ev));
            if (vecs[i].n_ev > 0) checkOutput($sformatf("vec%0d.rd_data", i), rd_data, vecs[i].ev);
            checkOutput($sformatf("vec%0d.sys_pulses", i), 16'(sys_pulses - base), 16'(vecs[i].n_sys));
            if (vecs[i].n_sys > 0) checkOutput($sformatf("vec%0d.sys_byte", i), 16'(sys_byte), 16'(vecs[i].sysb));
            if (vecs[i].n_ev == 1) begin
                popOnce();
                checkOutput($sformatf("vec%0d.pop_valid", i), 16'(rd_valid), 16'h0000);
                checkOutput($sformatf("vec%0d.pop_count", i), 16'(count), 16'h0000);
            end
        end

        // flush keeps sys_byte
        sendByte(8'hEE, 1);
        sendByte(8'h2A, 1);
        flushDut();
        checkOutput("flush.sys_byte", 16'(sys_byte), 16'h00EE);
        checkOutput("flush.count", 16'(count), 16'h0000);

        // Overflow: nine events into an eight-deep FIFO
        for (int i = 0; i < 9; i++) sendByte(8'h10 + 8'(i), 1);
        checkOutput("ovf.count", 16'(count), 16'd8);
        checkOutput("ovf.flag", 16'(overflow), 16'h0001);
        checkOutput("ovf.head", rd_data, 16'h0010);
        // push and pop land in the same cycle while full
        ps2_data     = 8'h30;
        ps2_data_clk = 1'b1;
        tick();
        ps2_data_clk = 1'b0;
        rd_pop       = 1'b1;
        tick();
        rd_pop = 1'b0;
        tick();
        checkOutput("fullpp.count", 16'(count), 16'd8);
        checkOutput("fullpp.flag", 16'(overflow), 16'h0001);
        checkOutput("fullpp.head", rd_data, 16'h0011);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checkOutput("ovf_clr.flag", 16'(overflow), 16'h0000);
        drain_exp = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016, 16'h0017, 16'h0030};
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("drain%0d", i), rd_data, drain_exp[i]);
            popOnce();
        end
        checkOutput("drain.count", 16'(count), 16'h0000);
        // push and pop in the same cycle while empty: pop ignored
        ps2_data     = 8'h31;
        ps2_data_clk = 1'b1;
        tick();
        ps2_data_clk = 1'b0;
        rd_pop       = 1'b1;
        tick();
        rd_pop = 1'b0;
        tick();
        checkOutput("emptypp.count", 16'(count), 16'h0001);
        checkOutput("emptypp.head", rd_data, 16'h0031);
        popOnce();
        popOnce();
        checkOutput("popempty.count", 16'(count), 16'h0000);
        checkOutput("popempty.valid", 16'(rd_valid), 16'h0000);

        // Timeout discards a stalled E0 prefix
        flushDut();
        sendByte(8'hE0, 1);
        repeat (TMO) tick();
        sendByte(8'h1C, 1);
        checkOutput("timeout.head", rd_data, 16'h001C);
        checkOutput("timeout.count", 16'(count), 16'h0001);
        flushDut();
        sendByte(8'hE0, 1);
        repeat (5) tick();
        sendByte(8'h1C, 1);
        checkOutput("notimeout.head", rd_data, 16'h401C);

        // Async reset in the middle of a release sequence
        flushDut();
        sendByte(8'hFA, 1);
        sendByte(8'h1C, 1);
        sendByte(8'h1D, 1);
        sendByte(8'h1E, 1);
        sendByte(8'hF0, 1);
        checkOutput("prerst.count", 16'(count), 16'd3);
        #3;
        reset_n = 1'b0;
        #1;
        checkAllZero("midrst");
        tick();
        reset_n = 1'b1;
        tick();
        modelReset();
        m_ovf  = 1'b0;
        m_sysb = 8'h00;
        sendByte(8'h1C, 1);
        checkOutput("postrst.head", rd_data, 16'h001C);
        checkOutput("postrst.count", 16'(count), 16'h0001);

        // Randomized traffic against the reference model
        flush   = 1'b1;
        ovf_clr = 1'b1;
        tick();
        flush   = 1'b0;
        ovf_clr = 1'b0;
        tick();
        modelReset();
        m_ovf     = 1'b0;
        m_sys_cnt = 0;
        base      = sys_pulses;
        for (int it = 0; it < 250; it++) begin
            act = int'($urandom_range(0, 9));
            if (act <= 5) begin
                case ($urandom_range(0, 15))
                    0: b = 8'hE0;
                    1: b = 8'hF0;
                    2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h5A;
                    3: b = ctrl_list[$urandom_range(0, 5)];
                    default: b = 8'($urandom_range(1, 127));
                endcase
                sendByte(b, int'($urandom_range(1, 4)));
            end else if (act <= 8) begin
                popOnce();
            end else begin
                ovf_clr = 1'b1;
                tick();
                ovf_clr = 1'b0;
                m_ovf   = 1'b0;
            end
            checkOutput($sformatf("rnd%0d.count", it), 16'(count), 16'(exp_q.size()));
            checkOutput($sformatf("rnd%0d.overflow", it), 16'(overflow), 16'(m_ovf));
            checkOutput($sformatf("rnd%0d.sys_byte", it), 16'(sys_byte), 16'(m_sysb));
            if (exp_q.size() > 0) checkOutput($sformatf("rnd%0d.head", it), rd_data, exp_q[0]);
        end
        checkOutput("rnd.sys_pulses", 16'(sys_pulses - base), 16'(m_sys_cnt));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_fifo.md
Name: ps2_scancode_fifo

Overview:
- Sits between the PS/2 keyboard controller's received-byte output (ps2_data / ps2_data_clk) and the port controller that serves the CPU's keyboard port.
- Decodes Set-2 scancode prefixes (E0, F0, E1-pause) into single 16-bit key events and buffers them in a FIFO.
- The CPU pops events through a port read strobe.
- Filters keyboard control replies (ACK, BAT, echo, resend, error) out of the event stream onto a separate status path.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, ≥2.
- TIMEOUT_CYC, 2000000, clk cycles a partial prefix sequence may stall before it is discarded (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous active-low reset.
- ps2_data  in  8  byte from PS/2 controller.
- ps2_data_clk  in  1  byte-valid strobe from PS/2 controller; may stay high for several clk cycles.
- rd_pop  in  1  pop head event; one pop per clk cycle it is high.
- flush  in  1  synchronous clear of FIFO and decoder.
- ovf_clr  in  1  clears overflow flag.
- rd_data  out  16  head event: [15] release, [14] extended, [13] pause, [12:8] 0, [7:0] code.
- rd_valid  out  1  FIFO not empty.
- count  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- sys_byte  out  8  last control byte received.
- sys_strobe  out  1  one-cycle pulse when sys_byte updates.

Behaviour:
- Reset: the asynchronous reset and flush produce identical state, except that flush leaves sys_byte and overflow unchanged.
  - rd_data=0, rd_valid=0, count=0, overflow=0, sys_byte=0, sys_strobe=0.
  - Decoder goes to IDLE; timeout counter=0; edge-detect register=0.
- Byte capture: register ps2_data_clk. A byte is accepted on the cycle where ps2_data_clk=1 and the previous value was 0. ps2_data is sampled in that same cycle. Exactly one accept per strobe, regardless of how long the strobe stays high.
- Decoder states: IDLE, E0, F0, E0F0, PAUSE.
  - IDLE:
    - E0 -> E0.
    - F0 -> F0.
    - E1 -> PAUSE with skip=7.
    - FA/AA/EE/FE/00/FF -> sys_byte<=byte, sys_strobe=1 the next cycle, stay IDLE, no push.
    - Any other byte -> push {0,0,0,code}.
  - E0: F0 -> E0F0; E0 -> E0; E1 -> PAUSE; else push {0,1,0,code} -> IDLE.
  - F0: push {1,0,0,code} -> IDLE. If byte=E0 -> E0 instead (malformed sequence, restart).
  - E0F0: push {1,1,0,code} -> IDLE. If byte=F0 or E0 -> IDLE, no push.
  - PAUSE: each accepted byte decrements skip. When skip reaches 0, push 16'h60E1 -> IDLE.
  - Control bytes are filtered only in IDLE. In other states they are treated as code bytes.
- Timeout:
  - Counter clears on every accepted byte and in IDLE.
  - In any non-IDLE state it increments each cycle.
  - At TIMEOUT_CYC-1 the decoder returns to IDLE and the partial sequence is discarded with no push.
- FIFO behaviour:
  - First-word-fall-through: rd_data is the head entry whenever rd_valid=1. rd_data is held at its last value (don't care) when empty.
  - Push is issued one cycle after the byte is accepted. It is written at the tail; count+1.
  - Pop when rd_valid=1: head advances, count-1, and new head data is visible the next cycle.
  - Pop when empty is ignored.
  - Simultaneous push and pop:
    - Not full and not empty: count unchanged, both take effect.
    - Full: the pop frees the slot and the push is stored; no overflow.
    - Empty: the pop is ignored and the push is stored.
  - Push when full without a pop: event dropped, overflow<=1.
  - ovf_clr has priority over a same-cycle overflow set (flag reads 0 after).
  - Pointers are clog2(DEPTH) bits wide and wrap naturally at DEPTH.
- flush takes priority over push and pop in the same cycle.

Test Plan:
- Send 1C (strobe held 3 cycles) -> exactly one event; rd_data=16'h001C, count=1; pop -> rd_valid=0, count=0.
- Send E0 F0 75 -> single event 16'hC075; send F0 1C -> 16'h801C; send E1 14 77 E1 F0 14 F0 77 -> single event 16'h60E1, no other pushes.
- Send FA then AA -> sys_strobe pulses twice, sys_byte=AA, count=0; send F0 FA -> event 16'h80FA pushed.
- With DEPTH=8, push 9 events -> count=8, overflow=1, 9th event lost; while full, push and pop in the same cycle -> count stays 8, overflow unchanged; ovf_clr -> overflow=0.
- Send E0, then idle TIMEOUT_CYC cycles, then 1C -> event 16'h001C (not 16'h401C).
- Assert reset_n=0 mid-sequence (after F0) with 3 events queued -> all outputs 0 immediately; after release, send 1C -> 16'h001C.
